disp_modectl: RTL and testbench
===============================

DISP_MODECTL -- requirements
Module: disp_modectl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RST_CYC  16  cycles the sync generator is held in reset per mode change (range 1..255)
  SETTLE_FRAMES  2  complete frames after reset release before display is enabled (range 1..7)
  DEF_RESOL  2'b00  resolution code applied out of reset
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  DCLK  in  1  dot clock; single clock domain
  DRST  in  1  reset; synchronous, active-high
  REQ_RESOL  in  2  requested resolution code
  REQ_VALID  in  1  request qualifier
  REQ_READY  out  1  request can be accepted this cycle
  REQ_ERR  out  1  one-cycle pulse when an accepted code is invalid
  VCNT  in  11  vertical counter from the sync generator
  SG_RST  out  1  reset to the sync generator, active-high
  SG_RESOL  out  2  resolution code driven to the sync generator
  DSP_ON  out  1  display data enable gate; high only in a stable mode
  BUSY  out  1  high whenever the state is not RUN

Function
REQ-003 Valid resolution codes SHALL be 2'b00, 2'b01 and 2'b10; 2'b11 is invalid.
REQ-004 Frame start SHALL be a one-cycle event: VCNT==0 AND registered previous VCNT!=0.
REQ-005 The FSM SHALL have four states: HOLD, SETTLE, RUN, DRAIN.
REQ-006 HOLD: SG_RST=1; an 8-bit counter SHALL count RST_CYC cycles, then the FSM enters SETTLE.
REQ-007 SETTLE: SG_RST=0; a 3-bit counter SHALL count frame starts, and on the SETTLE_FRAMES-th one the FSM enters RUN with DSP_ON=1 in the same register update.
REQ-008 RUN: REQ_READY=1; a handshake is REQ_VALID & REQ_READY on a DCLK edge.
REQ-009 Accepted code equal to SG_RESOL: no-op; stay RUN; DSP_ON unchanged.
REQ-010 Accepted invalid code: REQ_ERR pulses on the next cycle; stay RUN; nothing else changes.
REQ-011 Accepted valid, different code: the code SHALL be latched as pending and the FSM SHALL enter DRAIN.
REQ-012 DRAIN: REQ_READY=0 and DSP_ON stays 1 until a frame start; on that frame start, in the same register update, DSP_ON<=0, SG_RST<=1, SG_RESOL<=pending, the counter clears and the FSM enters HOLD.
REQ-013 REQ_READY SHALL be 0 outside RUN; REQ_VALID in those states SHALL be ignored and not queued.
REQ-014 SG_RESOL SHALL change only on entry to HOLD, i.e. only while SG_RST is asserted.
REQ-015 All outputs SHALL be registered; REQ_READY and BUSY SHALL be decoded from the registered state.
REQ-016 A frame start and a handshake in the same RUN cycle: the handshake SHALL take effect and that frame start is not used for DRAIN, so DRAIN waits for the next frame start.
REQ-017 The previous-VCNT register SHALL update in every state, so that a VCNT held at 0 under reset produces no frame start.

Reset
REQ-018 On DRST=1, state SHALL be HOLD and counters 0.
REQ-019 On DRST=1, outputs SHALL be SG_RST=1, SG_RESOL=DEF_RESOL, DSP_ON=0, REQ_ERR=0 and BUSY=1.
REQ-020 On DRST=1, the pending code SHALL be DEF_RESOL and previous VCNT SHALL be 0.
REQ-021 DRST asserted mid-operation (any state) SHALL abort it with the same values on the next edge.
REQ-022 After reset release the full HOLD then SETTLE sequence SHALL run before DSP_ON rises.

Structure
REQ-023 Shared package disp_pkg SHALL hold the state enumeration, the resolution code constants (including the invalid code) and the parameter defaults.
REQ-024 Frame-start detection SHALL be sub-module vwrap_det (inputs DCLK, DRST, VCNT; output FSTART).
REQ-025 Total RTL SHALL be 120-400 lines.

Verification (RST_CYC=4, SETTLE_FRAMES=1, sync generator model attached)
REQ-026 Reset release -> SG_RST high exactly 4 cycles; DSP_ON rises on the first frame start after that; REQ_READY=1 afterwards.
REQ-027 In RUN, REQ_RESOL=2'b01 with one-cycle VALID mid-frame -> READY low next cycle; DSP_ON stays high until the next frame start; then SG_RST=1 for 4 cycles with SG_RESOL=2'b01; DSP_ON returns after one frame.
REQ-028 REQ_RESOL equal to current SG_RESOL -> no SG_RST pulse; DSP_ON never drops; BUSY stays 0.
REQ-029 REQ_RESOL=2'b11 -> REQ_ERR high exactly one cycle; SG_RESOL unchanged; state RUN.
REQ-030 Handshake coincident with a frame start -> SG_RST is asserted only at the following frame start.
REQ-031 DRST pulsed during DRAIN or SETTLE -> next cycle SG_RST=1, SG_RESOL=DEF_RESOL, DSP_ON=0; full recovery sequence repeats.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display mode controller.
// Holds the FSM state encoding, the resolution codes and the parameter defaults.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [1:0] RESOL_0       = 2'b00;
  localparam logic [1:0] RESOL_1       = 2'b01;
  localparam logic [1:0] RESOL_2       = 2'b10;
  localparam logic [1:0] RESOL_INVALID = 2'b11;

  localparam int         RST_CYC_DEF       = 16;
  localparam int         SETTLE_FRAMES_DEF = 2;
  localparam logic [1:0] DEF_RESOL_DEF     = RESOL_0;

  function automatic logic resol_valid(input logic [1:0] code);
    return code != RESOL_INVALID;
  endfunction

endpackage

// File: rtl/vwrap_det.sv
// Frame-start detector: one-cycle pulse when the vertical counter wraps to zero.
// The previous-count register runs in every state so a counter parked at 0 never fires.
module vwrap_det (
  input  logic        DCLK,
  input  logic        DRST,
  input  logic [10:0] VCNT,
  output logic        FSTART
);

  logic [10:0] vcnt_prev;

  always_ff @(posedge DCLK) begin
    if (DRST) vcnt_prev <= '0;
    else      vcnt_prev <= VCNT;
  end

  assign FSTART = (VCNT == 11'd0) && (vcnt_prev != 11'd0);

endmodule

// File: rtl/disp_modectl.sv
// Display mode controller: sequences sync-generator reset, frame settling and
// glitch-free resolution changes aligned to frame boundaries.
//
// state  | meaning
// HOLD   | sync generator held in reset for RST_CYC cycles
// SETTLE | sync generator running, waiting SETTLE_FRAMES frame starts
// RUN    | stable mode, display enabled, requests accepted
// DRAIN  | change pending, display kept on until the next frame start
module disp_modectl
  import disp_pkg::*;
#(
  parameter int         RST_CYC       = RST_CYC_DEF,
  parameter int         SETTLE_FRAMES = SETTLE_FRAMES_DEF,
  parameter logic [1:0] DEF_RESOL     = DEF_RESOL_DEF
) (
  input  logic        DCLK,
  input  logic        DRST,
  input  logic [1:0]  REQ_RESOL,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  output logic        REQ_ERR,
  input  logic [10:0] VCNT,
  output logic        SG_RST,
  output logic [1:0]  SG_RESOL,
  output logic        DSP_ON,
  output logic        BUSY
);

  localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_FRAMES - 1);

  state_t     state;
  logic [7:0] rst_cnt;
  logic [2:0] frm_cnt;
  logic [1:0] pending;
  logic       sg_rst;
  logic [1:0] sg_resol;
  logic       dsp_on;
  logic       req_err;
  logic       fstart;
  logic       handshake;

  vwrap_det u_vwrap_det (
    .DCLK   (DCLK),
    .DRST   (DRST),
    .VCNT   (VCNT),
    .FSTART (fstart)
  );

  assign handshake = REQ_VALID && (state == ST_RUN);

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      state    <= ST_HOLD;
      rst_cnt  <= '0;
      frm_cnt  <= '0;
      pending  <= DEF_RESOL;
      sg_rst   <= 1'b1;
      sg_resol <= DEF_RESOL;
      dsp_on   <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            state   <= ST_SETTLE;
            sg_rst  <= 1'b0;
            rst_cnt <= '0;
            frm_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        ST_SETTLE: begin
          if (fstart) begin
            if (frm_cnt == SETTLE_LAST) begin
              state   <= ST_RUN;
              dsp_on  <= 1'b1;
              frm_cnt <= '0;
            end else begin
              frm_cnt <= frm_cnt + 3'd1;
            end
          end
        end
        ST_RUN: begin
          // A frame start in the handshake cycle is deliberately not consumed here.
          if (handshake && (REQ_RESOL != sg_resol)) begin
            if (!resol_valid(REQ_RESOL)) begin
              req_err <= 1'b1;
            end else begin
              pending <= REQ_RESOL;
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fstart) begin
            dsp_on   <= 1'b0;
            sg_rst   <= 1'b1;
            sg_resol <= pending;
            rst_cnt  <= '0;
            state    <= ST_HOLD;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign REQ_READY = (state == ST_RUN);
  assign BUSY      = (state != ST_RUN);
  assign REQ_ERR   = req_err;
  assign SG_RST    = sg_rst;
  assign SG_RESOL  = sg_resol;
  assign DSP_ON    = dsp_on;

endmodule

// File: tb/tb_disp_modectl.sv
// Bench for disp_modectl with a small sync-generator model (20 lines per frame).
// Request vectors come from a table; reset and coincidence corners are hand sequences.
module tb_disp_modectl;

  localparam int RST_CYC = 4;
  localparam int VTOT    = 20;

  logic        DCLK = 1'b0;
  logic        DRST;
  logic [1:0]  REQ_RESOL;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_ERR;
  logic [10:0] VCNT = '0;
  logic        SG_RST;
  logic [1:0]  SG_RESOL;
  logic        DSP_ON;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] resol;
    logic       exp_err;
    logic       exp_change;
    logic [1:0] exp_resol;
  } vec_t;

  vec_t vecs [7];

  disp_modectl #(
    .RST_CYC       (RST_CYC),
    .SETTLE_FRAMES (1),
    .DEF_RESOL     (2'b00)
  ) dut (
    .DCLK      (DCLK),
    .DRST      (DRST),
    .REQ_RESOL (REQ_RESOL),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_ERR   (REQ_ERR),
    .VCNT      (VCNT),
    .SG_RST    (SG_RST),
    .SG_RESOL  (SG_RESOL),
    .DSP_ON    (DSP_ON),
    .BUSY      (BUSY)
  );

  always #5 DCLK = ~DCLK;

  // Sync generator: counter parked at 0 while held in reset.
  always @(posedge DCLK) begin
    if (SG_RST === 1'b1)     VCNT <= '0;
    else if (VCNT == VTOT-1) VCNT <= '0;
    else                     VCNT <= VCNT + 11'd1;
  end

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_vcnt(input int v);
    int n = 0;
    while (VCNT != 11'(v) && n < 200) begin
      tick();
      n++;
    end
    check("wait_vcnt_bound", int'(n < 200), 1);
  endtask

  // Starts on the first sample with SG_RST high; measures hold and settle lengths.
  task automatic measure_recovery(input logic [1:0] exp_resol);
    int hi = 0;
    int lo = 0;
    bit resol_ok = 1;
    while (SG_RST && hi < 300) begin
      if (SG_RESOL !== exp_resol || DSP_ON !== 1'b0) resol_ok = 0;
      tick();
      hi++;
    end
    check("hold_len", hi, RST_CYC);
    while (!DSP_ON && lo < 300) begin
      tick();
      lo++;
    end
    check("settle_len", lo, VTOT + 1);
    check("hold_resol_stable", int'(resol_ok), 1);
    check("run_ready", int'(REQ_READY), 1);
    check("run_busy", int'(BUSY), 0);
    check("run_resol", int'(SG_RESOL), int'(exp_resol));
  endtask

  task automatic apply_vec(input vec_t v);
    int n = 0;
    bit ok = 1;
    wait_vcnt(5);
    REQ_RESOL = v.resol;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    check("ready_after_hs", int'(REQ_READY), int'(!v.exp_change));
    check("err_after_hs", int'(REQ_ERR), int'(v.exp_err));
    check("busy_after_hs", int'(BUSY), int'(v.exp_change));
    check("dsp_after_hs", int'(DSP_ON), 1);
    if (v.exp_change) begin
      // Requests during DRAIN must be ignored entirely.
      REQ_RESOL = 2'b11;
      REQ_VALID = 1'b1;
      while (!SG_RST && n < 200) begin
        if (!DSP_ON || REQ_ERR || REQ_READY) ok = 0;
        tick();
        n++;
      end
      REQ_VALID = 1'b0;
      check("drain_len", n, VTOT - 5);
      check("drain_dsp_held", int'(ok), 1);
      check("hold_dsp_off", int'(DSP_ON), 0);
      check("hold_new_resol", int'(SG_RESOL), int'(v.exp_resol));
      measure_recovery(v.exp_resol);
    end else begin
      tick();
      check("err_one_cycle", int'(REQ_ERR), 0);
      for (int i = 0; i < VTOT + 5; i++) begin
        if (SG_RST || !DSP_ON || BUSY || REQ_ERR) ok = 0;
        tick();
      end
      check("noop_stable", int'(ok), 1);
      check("noop_resol", int'(SG_RESOL), int'(v.exp_resol));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sg_rst"}, int'(SG_RST), 1);
    check({tag, "_sg_resol"}, int'(SG_RESOL), 0);
    check({tag, "_dsp_on"}, int'(DSP_ON), 0);
    check({tag, "_req_err"}, int'(REQ_ERR), 0);
    check({tag, "_busy"}, int'(BUSY), 1);
    check({tag, "_ready"}, int'(REQ_READY), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{2'b01, 1'b0, 1'b1, 2'b01};
    vecs[1] = '{2'b01, 1'b0, 1'b0, 2'b01};
    vecs[2] = '{2'b11, 1'b1, 1'b0, 2'b01};
    vecs[3] = '{2'b10, 1'b0, 1'b1, 2'b10};
    vecs[4] = '{2'b00, 1'b0, 1'b1, 2'b00};
    vecs[5] = '{2'b00, 1'b0, 1'b0, 2'b00};
    vecs[6] = '{2'b11, 1'b1, 1'b0, 2'b00};

    DRST      = 1'b1;
    REQ_VALID = 1'b0;
    REQ_RESOL = 2'b00;
    repeat (3) tick();
    check_reset_vals("por");
    DRST = 1'b0;
    measure_recovery(2'b00);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Handshake landing on a frame start: drain waits a full frame.
    wait_vcnt(VTOT - 1);
    tick();
    check("coinc_vcnt_zero", int'(VCNT), 0);
    REQ_RESOL = 2'b01;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    n = 0;
    while (!SG_RST && n < 200) begin
      tick();
      n++;
    end
    check("coinc_drain_len", n, VTOT);
    check("coinc_resol", int'(SG_RESOL), 1);
    measure_recovery(2'b01);

    // Reset during DRAIN.
    wait_vcnt(5);
    REQ_RESOL = 2'b10;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    repeat (3) tick();
    check("drain_busy", int'(BUSY), 1);
    check("drain_dsp", int'(DSP_ON), 1);
    DRST = 1'b1;
    tick();
    check_reset_vals("rst_drain");
    DRST = 1'b0;
    measure_recovery(2'b00);

    // Reset during SETTLE.
    DRST = 1'b1;
    tick();
    DRST = 1'b0;
    n = 0;
    while (SG_RST && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("settle_busy", int'(BUSY), 1);
    check("settle_dsp", int'(DSP_ON), 0);
    DRST = 1'b1;
    tick();
    check_reset_vals("rst_settle");
    DRST = 1'b0;
    measure_recovery(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
